a7_ddr3_wr_burst_gen: RTL and testbench

- Upstream command/data source for the DDR3 write controller.
- Monitors a first-word-fall-through (FWFT) 128-bit write FIFO filled by the video/HDMI capture side.
- Whenever a full burst is buffered, issues one write command (start, bl, addr, mask) and streams FIFO words on the controller's data_req.
- Walks a linear frame buffer and wraps at frame end; checks burst integrity.

---
 rtl/a7_ddr3_wr_burst_gen.sv | 192 +++++++++++++++++++
 tb/tb_a7_ddr3_wr_burst_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a7_ddr3_wr_burst_gen.sv
// -----------------------------------------------------------------------------
// a7_ddr3_wr_burst_gen
// Write-burst generator feeding the DDR3 write controller. It watches a
// first-word-fall-through 128-bit FIFO, and each time a whole burst is buffered
// it issues one write command. It then streams FIFO words on data_req and
// advances a linear frame-buffer address that wraps at frame end. It also
// checks that every burst delivered exactly BURST_LEN beats.
//
// Optional build macro: WR_PINGPONG_EN
//   When defined, the block adds a 'bank' output. Each natural frame wrap
//   toggles the bank, and while bank=1 the command address is offset by
//   BANK_OFFSET.
// -----------------------------------------------------------------------------
module a7_ddr3_wr_burst_gen #(
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned FRAME_BEATS = 518400,
  parameter logic [27:0] BASE_ADDR   = 28'h0000000,
  parameter logic [27:0] BANK_OFFSET = 28'h0800000
) (
  input  logic         sclk,
  input  logic         rst_n,
  input  logic         wr_enable,
  input  logic         frame_rst,
  input  logic [9:0]   fifo_rd_count,
  input  logic [127:0] fifo_rd_data,
  output logic         fifo_rd_en,
  output logic         wr_cmd_start,
  output logic [2:0]   wr_cmd_instr,
  output logic [6:0]   wr_cmd_bl,
  output logic [27:0]  wr_cmd_addr,
  output logic [15:0]  wr_cmd_mask,
  output logic [127:0] data_128bit,
  input  logic         data_req,
  input  logic         wr_end,
  output logic         frame_done,
  output logic         burst_err
`ifdef WR_PINGPONG_EN
  ,
  output logic         bank
`endif
);

  localparam int unsigned       FB_W        = $clog2(FRAME_BEATS + 1);
  localparam logic [FB_W-1:0]   L_BURST_FB  = FB_W'(BURST_LEN);
  localparam logic [FB_W-1:0]   L_FRAME     = FB_W'(FRAME_BEATS);
  localparam logic [27:0]       L_ADDR_STEP = 28'(BURST_LEN * 8);
  localparam logic [7:0]        L_BURST_B   = 8'(BURST_LEN);
  localparam logic [9:0]        L_BURST_CNT = 10'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_END,
    S_UPDATE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_fifo_rd_en;

  logic              r_wr_cmd_start;
  logic [27:0]       r_wr_cmd_addr;
  logic [27:0]       r_addr;
  logic [7:0]        r_beat_cnt;
  logic [FB_W-1:0]   r_frame_beats;
  logic              r_pending;
  logic              r_frame_done;
  logic              r_burst_err;

  logic              w_bank;
  logic [FB_W-1:0]   w_fb_next;
  logic              w_wrap;
  logic              w_restart;
  logic              w_natural_wrap;
  logic              w_start_cond;

  // Fixed command fields and the FWFT data pass-through.
  assign wr_cmd_instr = 3'b000;
  assign wr_cmd_mask  = 16'h0000;
  assign wr_cmd_bl    = 7'(BURST_LEN);
  assign data_128bit  = fifo_rd_data;

  assign wr_cmd_start = r_wr_cmd_start;
  assign wr_cmd_addr  = r_wr_cmd_addr;
  assign frame_done   = r_frame_done;
  assign burst_err    = r_burst_err;
  assign fifo_rd_en   = w_fifo_rd_en;

  // A frame_rst seen in IDLE wins over a start in that same cycle.
  assign w_start_cond   = wr_enable && (fifo_rd_count >= L_BURST_CNT) && !frame_rst;
  assign w_fb_next      = r_frame_beats + L_BURST_FB;
  assign w_wrap         = (w_fb_next >= L_FRAME);
  assign w_restart      = r_pending || frame_rst;
  assign w_natural_wrap = (r_state == S_UPDATE) && w_wrap && !w_restart;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and the combinational FIFO pop.
  // NOTE: every output of this block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next       = r_state;
    w_fifo_rd_en = 1'b0;
    case (r_state)
      S_IDLE:     if (w_start_cond) w_next = S_START;
      S_START:    w_next = S_WAIT_END;
      S_WAIT_END: begin
        w_fifo_rd_en = data_req;
        if (wr_end) w_next = S_UPDATE;
      end
      S_UPDATE:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Command, address walk, beat/frame counting and integrity tracking.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cmd_start <= 1'b0;
      r_wr_cmd_addr  <= 28'h0;
      r_addr         <= BASE_ADDR;
      r_beat_cnt     <= 8'd0;
      r_frame_beats  <= '0;
      r_pending      <= 1'b0;
      r_frame_done   <= 1'b0;
      r_burst_err    <= 1'b0;
    end else begin
      r_wr_cmd_start <= (w_next == S_START);
      r_frame_done   <= 1'b0;

      // Address is captured once per burst and held until the next start.
      if (w_next == S_START)
        r_wr_cmd_addr <= r_addr + (w_bank ? BANK_OFFSET : 28'h0);

      // A data request outside the data phase is a protocol error.
      if (data_req && (r_state != S_WAIT_END))
        r_burst_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (frame_rst) begin
            r_addr        <= BASE_ADDR;
            r_frame_beats <= '0;
          end
        end
        S_START: begin
          if (frame_rst) r_pending <= 1'b1;
        end
        S_WAIT_END: begin
          if (frame_rst) r_pending <= 1'b1;
          if (data_req && (r_beat_cnt != 8'hFF))
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
        S_UPDATE: begin
          if (r_beat_cnt != L_BURST_B) r_burst_err <= 1'b1;
          r_beat_cnt <= 8'd0;
          if (w_wrap || w_restart) begin
            r_addr        <= BASE_ADDR;
            r_frame_beats <= '0;
            r_pending     <= 1'b0;
            r_frame_done  <= !w_restart;
          end else begin
            r_addr        <= r_addr + L_ADDR_STEP;
            r_frame_beats <= w_fb_next;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WR_PINGPONG_EN
  logic r_bank;
  assign w_bank = r_bank;
  assign bank   = r_bank;

  // Bank flips on a natural frame wrap, in step with frame_done.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n)              r_bank <= 1'b0;
    else if (w_natural_wrap) r_bank <= ~r_bank;
  end
`else
  assign w_bank = 1'b0;
`endif

endmodule

// File: tb/tb_a7_ddr3_wr_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_a7_ddr3_wr_burst_gen
// Self-checking bench. The DUT runs with BURST_LEN=64 and FRAME_BEATS=128, so
// one frame is two bursts. A bench-side FIFO serves numbered words. Expected
// command addresses and expected data words go into scoreboard queues as
// stimulus is driven, and are popped when the DUT presents them. Honours
// WR_PINGPONG_EN when defined.
// -----------------------------------------------------------------------------
module tb_a7_ddr3_wr_burst_gen;

`ifdef WR_PINGPONG_EN
  localparam logic [27:0] BANK_OFF = 28'h0800000;
`else
  localparam logic [27:0] BANK_OFF = 28'h0;
`endif

  logic         sclk;
  logic         rst_n;
  logic         wr_enable;
  logic         frame_rst;
  logic [9:0]   fifo_rd_count;
  logic [127:0] fifo_rd_data;
  logic         fifo_rd_en;
  logic         wr_cmd_start;
  logic [2:0]   wr_cmd_instr;
  logic [6:0]   wr_cmd_bl;
  logic [27:0]  wr_cmd_addr;
  logic [15:0]  wr_cmd_mask;
  logic [127:0] data_128bit;
  logic         data_req;
  logic         wr_end;
  logic         frame_done;
  logic         burst_err;
`ifdef WR_PINGPONG_EN
  logic         bank;
`endif

  a7_ddr3_wr_burst_gen #(
    .BURST_LEN   (64),
    .FRAME_BEATS (128),
    .BASE_ADDR   (28'h0000000),
    .BANK_OFFSET (28'h0800000)
  ) u_dut (
    .sclk          (sclk),
    .rst_n         (rst_n),
    .wr_enable     (wr_enable),
    .frame_rst     (frame_rst),
    .fifo_rd_count (fifo_rd_count),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .wr_cmd_start  (wr_cmd_start),
    .wr_cmd_instr  (wr_cmd_instr),
    .wr_cmd_bl     (wr_cmd_bl),
    .wr_cmd_addr   (wr_cmd_addr),
    .wr_cmd_mask   (wr_cmd_mask),
    .data_128bit   (data_128bit),
    .data_req      (data_req),
    .wr_end        (wr_end),
    .frame_done    (frame_done),
    .burst_err     (burst_err)
`ifdef WR_PINGPONG_EN
    ,
    .bank          (bank)
`endif
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Bench FIFO: the head word is a known function of the pop index.
  function automatic logic [127:0] word(int unsigned i);
    logic [31:0] v;
    v = i;
    return {v ^ 32'hA5A5_0000, ~v, v * 32'h9E37_79B9, 32'hC0DE_0000 + v};
  endfunction

  int unsigned rd_ptr = 0;
  assign fifo_rd_data = word(rd_ptr);

  // Pop the bench FIFO whenever the DUT asserts fifo_rd_en.
  always @(posedge sclk) begin
    if (fifo_rd_en === 1'b1) rd_ptr <= rd_ptr + 1;
  end

  // Scoreboards and reference state.
  logic [27:0]  addr_q[$];
  logic [127:0] exp_q[$];
  int unsigned  exp_ptr = 0;
  int unsigned  pop_base;
  logic [27:0]  m_addr;
  int           m_beats;
  logic         m_pend;
  logic         m_bank;
  logic         m_err;
  logic         exp_done;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_addr  = 28'h0;
    m_beats = 0;
    m_pend  = 1'b0;
    m_bank  = 1'b0;
    m_err   = 1'b0;
  endtask

  // Reference update applied once a burst completes (n = beats delivered).
  task automatic model_update(input int n);
    if (n != 64) m_err = 1'b1;
    m_beats  = m_beats + 64;
    exp_done = 1'b0;
    if (m_beats >= 128 || m_pend) begin
      if (!m_pend) begin
        exp_done = 1'b1;
        m_bank   = ~m_bank;
      end
      m_addr  = 28'h0;
      m_beats = 0;
      m_pend  = 1'b0;
    end else begin
      m_addr = m_addr + 28'h200;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge in WAIT_END.
  task automatic start_burst(input string tag);
    addr_q.push_back(m_addr + (m_bank ? BANK_OFF : 28'h0));
    pop_base      = rd_ptr;
    fifo_rd_count = 10'd64;
    @(negedge sclk);
    check({tag, "_start"}, wr_cmd_start, 1'b1);
    check({tag, "_addr"}, wr_cmd_addr, addr_q.pop_front());
    check({tag, "_done_low"}, frame_done, 1'b0);
    fifo_rd_count = 10'd0;
    @(negedge sclk);
    check({tag, "_start_1cyc"}, wr_cmd_start, 1'b0);
  endtask

  // Delivers n data requests with random gaps; frame_rst pulses at beat rst_at.
  task automatic do_beats(input int n, input int rst_at);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        data_req = 1'b0;
        @(negedge sclk);
        frame_rst = 1'b0;
      end
      if (k == rst_at) begin
        frame_rst = 1'b1;
        m_pend    = 1'b1;
      end
      data_req = 1'b1;
      exp_q.push_back(word(exp_ptr));
      exp_ptr++;
      #1;
      check("rd_en", fifo_rd_en, 1'b1);
      check("data", data_128bit, exp_q.pop_front());
      @(negedge sclk);
      frame_rst = 1'b0;
    end
    data_req = 1'b0;
  endtask

  // Signals wr_end and checks the results of the completed burst.
  task automatic end_burst(input string tag, input int n);
    data_req = 1'b0;
    wr_end   = 1'b1;
    @(negedge sclk);
    wr_end = 1'b0;
    check({tag, "_done_upd"}, frame_done, 1'b0);
    model_update(n);
    @(negedge sclk);
    check({tag, "_frame_done"}, frame_done, exp_done);
    check({tag, "_burst_err"}, burst_err, m_err);
    check({tag, "_pops"}, 32'(rd_ptr - pop_base), 32'(n));
`ifdef WR_PINGPONG_EN
    check({tag, "_bank"}, bank, m_bank);
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    wr_enable     = 1'b0;
    frame_rst     = 1'b0;
    fifo_rd_count = 10'd0;
    data_req      = 1'b0;
    wr_end        = 1'b0;
    exp_done      = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge sclk);
    check("rst_start", wr_cmd_start, 1'b0);
    check("rst_addr", wr_cmd_addr, 28'h0);
    check("rst_bl", wr_cmd_bl, 7'd64);
    check("rst_instr", wr_cmd_instr, 3'b000);
    check("rst_mask", wr_cmd_mask, 16'h0000);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_err", burst_err, 1'b0);
    rst_n = 1'b1;
    @(negedge sclk);

    // One word short of a burst: no command.
    wr_enable     = 1'b1;
    fifo_rd_count = 10'd63;
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      check("ramp63_no_start", wr_cmd_start, 1'b0);
    end

    // Burst 1 at 0x000, burst 2 at 0x200 closes the frame.
    start_burst("b1");
    do_beats(64, -1);
    end_burst("b1", 64);
    start_burst("b2");
    do_beats(64, -1);
    end_burst("b2", 64);

    // Burst 3 wraps to base (bank 1 with ping-pong) and is one beat short.
    start_burst("b3");
    do_beats(63, -1);
    end_burst("b3", 63);

    // Stray data_req while idle: no pop, error stays set.
    data_req = 1'b1;
    #1;
    check("stray_rd_en", fifo_rd_en, 1'b0);
    @(negedge sclk);
    data_req = 1'b0;
    check("stray_err_sticky", burst_err, 1'b1);
    check("stray_no_pop", 32'(rd_ptr - pop_base), 32'd63);

    // frame_rst in IDLE beats a same-cycle start by one cycle.
    frame_rst     = 1'b1;
    fifo_rd_count = 10'd64;
    m_addr        = 28'h0;
    m_beats       = 0;
    @(negedge sclk);
    check("frs_idle_delay", wr_cmd_start, 1'b0);
    frame_rst = 1'b0;
    start_burst("b4");
    // frame_rst mid-burst: next burst restarts at base instead of 0x200.
    do_beats(64, 20);
    end_burst("b4", 64);

    start_burst("b5");
    do_beats(64, -1);
    end_burst("b5", 64);

    // frame_rst during the 0x200 burst: restart, no frame_done.
    start_burst("b6");
    do_beats(64, 5);
    end_burst("b6", 64);
    check("b6_err_sticky", burst_err, 1'b1);

    // Async reset in the middle of a burst at 0x200.
    start_burst("b7");
    do_beats(64, -1);
    end_burst("b7", 64);
    start_burst("b8");
    do_beats(10, -1);
    data_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd_en", fifo_rd_en, 1'b0);
    check("arst_start", wr_cmd_start, 1'b0);
    check("arst_addr", wr_cmd_addr, 28'h0);
    check("arst_done", frame_done, 1'b0);
    check("arst_err", burst_err, 1'b0);
`ifdef WR_PINGPONG_EN
    check("arst_bank", bank, 1'b0);
`endif
    data_req = 1'b0;
    @(negedge sclk);
    rst_n = 1'b1;
    model_reset();
    @(negedge sclk);

    // First burst after reset starts at base and completes cleanly.
    start_burst("b9");
    do_beats(64, -1);
    end_burst("b9", 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
